// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: RAM read port plus consumer valid/ready.
interface fifo_rd_ctrl_if #(
  parameter int AW         = 4,
  parameter int FIFO_WIDTH = 32
);
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [FIFO_WIDTH-1:0] mem_rd_data;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [FIFO_WIDTH-1:0] rd_data;

  modport master (output mem_rd_en, mem_rd_addr, rd_valid, rd_data,
                  input  mem_rd_data, rd_ready);
  modport slave  (input  mem_rd_en, mem_rd_addr, rd_valid, rd_data,
                  output mem_rd_data, rd_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: wptr synchronizer, Gray read pointer,
// fill level / almost-empty, RAM read port, standard or FWFT output stage.
module fifo_rd_ctrl #(
  parameter int  FIFO_DEPTH  = 16,
  parameter int  FIFO_WIDTH  = 32,
  parameter int  SYNC_STAGES = 2,
  parameter int  FWFT        = 0,
  parameter int  AE_THRESH   = 2,
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic           r_clk,
  input  logic           rst_n,
  input  logic [AW:0]    wptr_gray,
  output logic [AW:0]    rptr_gray,
  output logic [AW:0]    rd_level,
  output logic           empty,
  output logic           almost_empty,
  output logic           underflow,
  fifo_rd_ctrl_if.master bus
);

  logic [SYNC_STAGES-1:0][AW:0] wsync_q;
  logic [AW:0]                  wsync_last;
  logic [AW:0]                  wptr_bin_s;
  logic [AW:0]                  rptr_bin;
  logic [AW:0]                  rptr_bin_nxt;
  logic                         fetch;

  always_ff @(posedge r_clk or negedge rst_n)
    if (!rst_n) wsync_q <= '0;
    else        wsync_q <= {wsync_q[SYNC_STAGES-2:0], wptr_gray};

  assign wsync_last = wsync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wptr_bin_s = '0;
    for (int i = 0; i <= AW; i++)
      wptr_bin_s[i] = ^(wsync_last >> i);
  end

  assign rptr_bin_nxt = rptr_bin + (AW+1)'(fetch);

  always_ff @(posedge r_clk or negedge rst_n)
    if (!rst_n) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
    end else begin
      rptr_bin  <= rptr_bin_nxt;
      rptr_gray <= rptr_bin_nxt ^ (rptr_bin_nxt >> 1);
    end

  assign empty            = (rptr_bin == wptr_bin_s);
  assign rd_level         = wptr_bin_s - rptr_bin;
  assign almost_empty     = (32'(rd_level) <= 32'(AE_THRESH));
  assign bus.mem_rd_en    = fetch;
  assign bus.mem_rd_addr  = rptr_bin[AW-1:0];

  if (FWFT == 0) begin : g_std
    logic                  rd_vld_q;
    logic                  uf_q;
    logic [FIFO_WIDTH-1:0] hold_q;

    assign fetch = bus.rd_ready && !empty;

    always_ff @(posedge r_clk or negedge rst_n)
      if (!rst_n) begin
        rd_vld_q <= 1'b0;
        uf_q     <= 1'b0;
        hold_q   <= '0;
      end else begin
        rd_vld_q <= fetch;
        uf_q     <= bus.rd_ready && empty;
        if (rd_vld_q) hold_q <= bus.mem_rd_data;
      end

    // The RAM output register supplies the beat; hold_q keeps it afterwards.
    assign bus.rd_valid = rd_vld_q;
    assign bus.rd_data  = rd_vld_q ? bus.mem_rd_data : hold_q;
    assign underflow    = uf_q;
  end else begin : g_fwft
    logic [1:0][FIFO_WIDTH-1:0] buf_q;
    logic [1:0]                 buf_cnt;
    logic [1:0]                 cnt_pop;
    logic                       inflight;
    logic                       pop;

    assign pop     = (buf_cnt != 2'd0) && bus.rd_ready;
    assign cnt_pop = buf_cnt - 2'(pop);
    // Never request more than the 2-entry buffer can absorb after this pop.
    assign fetch   = !empty && (({1'b0, cnt_pop} + 3'(inflight)) < 3'd2);

    always_ff @(posedge r_clk or negedge rst_n)
      if (!rst_n) begin
        buf_q    <= '0;
        buf_cnt  <= 2'd0;
        inflight <= 1'b0;
      end else begin
        if (pop)      buf_q[0]          <= buf_q[1];
        if (inflight) buf_q[cnt_pop[0]] <= bus.mem_rd_data;
        buf_cnt  <= cnt_pop + 2'(inflight);
        inflight <= fetch;
      end

    assign bus.rd_valid = (buf_cnt != 2'd0);
    assign bus.rd_data  = buf_q[0];
    assign underflow    = 1'b0;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller for the async FIFO, successor to the basic read-pointer block.
- Adds an integrated write-pointer synchronizer, a registered Gray read pointer, fill level and almost-empty flag, a memory read port, and selectable standard or first-word-fall-through (FWFT) output with a valid/ready handshake.
- Sits in the r_clk domain between the dual-port FIFO RAM and the consumer.

Parameters:
- FIFO_DEPTH, 16, entries; power of two, >= 4; AW = log2(FIFO_DEPTH).
- FIFO_WIDTH, 32, data bits.
- SYNC_STAGES, 2, flops in the wptr synchronizer; legal range 2..4.
- FWFT, 0, 0 = standard read, 1 = first-word-fall-through.
- AE_THRESH, 2, almost_empty asserts when rd_level <= AE_THRESH.

Ports:
- r_clk  in  1  read clock.
- rst_n  in  1  asynchronous active-low reset.
- wptr_gray  in  AW+1  write pointer, Gray coded, from the w_clk domain (unsynchronized).
- rptr_gray  out  AW+1  registered Gray read pointer, to the write domain.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  AW  RAM read address, equal to rptr_bin[AW-1:0].
- mem_rd_data  in  FIFO_WIDTH  RAM data, valid 1 cycle after mem_rd_en.
- rd_ready  in  1  consumer pop/ready.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  FIFO_WIDTH  read data.
- empty  out  1  no unread entries in the RAM.
- almost_empty  out  1  level at or below AE_THRESH.
- rd_level  out  AW+1  synchronized fill level (0..FIFO_DEPTH).
- underflow  out  1  one-cycle pulse: read request while empty (FWFT=0 only).

Behaviour:
- Reset is asynchronous: rst_n=0 drives all of the following to 0 immediately: rptr_bin, rptr_gray, synchronizer flops, rd_valid, rd_data, rd_level, underflow, the FWFT buffer and in-flight flag. empty=1 and almost_empty=1 during reset.
- Synchronizer: wptr_gray passes through SYNC_STAGES flops. The last stage is Gray-to-binary converted to wptr_bin_s. There is no other combinational path from wptr_gray.
- rptr_gray is registered: (rptr_bin_next>>1)^rptr_bin_next, updated on the same edge as rptr_bin. It changes at most 1 bit per cycle.
- empty = (rptr_bin == wptr_bin_s), a full AW+1 bit compare. It is combinational from registers.
- rd_level = (wptr_bin_s - rptr_bin) mod 2^(AW+1).
- almost_empty = (rd_level <= AE_THRESH).
- Pointer wrap: rptr_bin increments modulo 2^(AW+1). The MSB toggles after every FIFO_DEPTH reads, and the address wraps from DEPTH-1 to 0.
- A fetch is mem_rd_en=1 with mem_rd_addr=rptr_bin[AW-1:0], which increments rptr_bin on that edge. A fetch never occurs while empty=1.
- FWFT=0 (standard read):
  - rd_ready acts as a read enable; a fetch happens when rd_ready && !empty.
  - rd_data is registered from mem_rd_data, and rd_valid pulses exactly 1 cycle after the fetch. Latency is 1 cycle.
  - rd_ready && empty produces no fetch, no pointer change, and underflow=1 for one cycle.
  - rd_data holds its last value when rd_valid=0.
- FWFT=1:
  - 2-entry output buffer plus one in-flight flag.
  - Fetch when !empty && (buf_count + inflight - pop) < 2, where pop = rd_valid && rd_ready.
  - Returned data is written to the buffer tail 1 cycle after the fetch.
  - rd_valid = (buf_count != 0); rd_data = buffer head.
  - With continuous rd_ready and a non-empty FIFO, sustained throughput is 1 word/cycle.
  - First-word latency after empty deasserts is 2 r_clk cycles, to rd_valid=1.
  - rd_data is stable while rd_valid && !rd_ready. underflow is tied to 0.
- empty reflects only RAM contents. In FWFT mode words still in the buffer are not counted in rd_level.
- Simultaneous fetch and wptr update: rd_level and empty use the registered pointers of the current cycle. A stale (conservative) empty is legal. A false non-empty is forbidden.
- Reset mid-operation: the buffer is discarded and the pointers return to 0. The write side must be reset concurrently.

Test Plan:
- Reset: rst_n=0 mid-stream with FWFT=1 and 2 words buffered -> rd_valid=0, rptr_gray=0, empty=1 immediately, with no r_clk edge needed.
- Sync latency: SYNC_STAGES=2, wptr_gray steps 0->1 (Gray) -> empty falls on the 2nd r_clk edge; rd_level=1; almost_empty stays 1 (AE_THRESH=2).
- Standard read: 3 words (0xA,0xB,0xC) written, rd_ready held 4 cycles -> rd_valid pulses 3 times with data A,B,C at fetch+1; underflow=1 on the 4th cycle; rptr_gray ends at 2 (binary 3).
- FWFT streaming: 16 words 0..15, rd_ready=1 -> rd_valid rises 2 cycles after empty falls; 16 consecutive beats 0..15 with no bubbles.
- FWFT backpressure: rd_ready=0 for 5 cycles with 8 words available -> exactly 2 fetches; rd_data=word0 stays stable; rd_level=6; on release the data order is preserved.
- Wrap: 40 words streamed through a depth-16 FIFO -> address wraps 15->0 twice; rptr_gray sequence changes 1 bit per update; data is in order with no loss.
